// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer.
// Op codes, sequencer states and the flag bundle.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_MOD = 4'b0100,
    OP_AND = 4'b0101,
    OP_OR  = 4'b0110,
    OP_XOR = 4'b0111,
    OP_SHL = 4'b1000,
    OP_SHR = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DIV,
    RESP
  } seq_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

  function automatic logic is_div_op(
    input logic [3:0] op
  );
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// quot/rem show the post-step values, valid while done is high.
module alu_seq_div
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         dz
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0] q;
  logic [N-1:0] r;
  logic [N-1:0] d;
  logic [CW-1:0] cnt;
  logic [N:0]   r_shift;
  logic [N+1:0] diff;
  logic         ge;
  logic [N-1:0] q_next;
  logic [N-1:0] r_next;

  // One restoring step: shift in next dividend bit, try subtract.
  always_comb begin
    r_shift = {r, q[N-1]};
    diff    = {1'b0, r_shift} - {2'b00, d};
    ge      = ~diff[N+1];
    r_next  = ge ? diff[N-1:0] : r_shift[N-1:0];
    q_next  = {q[N-2:0], ge};
  end

  assign done = busy && (cnt == CW'(1));
  assign quot = q_next;
  assign rem  = r_next;
  assign dz   = (d == '0);

  // Load operands on start, then iterate exactly N steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      q    <= a;
      r    <= '0;
      d    <= b;
      cnt  <= CW'(N);
      busy <= 1'b1;
    end else if (busy) begin
      q   <= q_next;
      r   <= r_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Registered command front-end driving a combinational ALU.
// Define ALU_SEQ_DIV_EN to run DIV/MOD on the internal divider.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_out,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v,
  input  logic         alu_c,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_z,
  output logic         rsp_n,
  output logic         rsp_v,
  output logic         rsp_c
);

  seq_state_e state;
  flags_t     rsp_f;
  logic       accept;
  logic       div_go;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign rsp_z = rsp_f.z;
  assign rsp_n = rsp_f.n;
  assign rsp_v = rsp_f.v;
  assign rsp_c = rsp_f.c;

`ifdef ALU_SEQ_DIV_EN
  logic         div_busy;
  logic         div_done;
  logic         div_dz;
  logic [N-1:0] div_quot;
  logic [N-1:0] div_rem;
  logic [N-1:0] div_res;
  flags_t       div_f;

  assign div_go = is_div_op(cmd_op);

  alu_seq_div #(
    .N(N)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept && div_go),
    .a    (cmd_a),
    .b    (cmd_b),
    .busy (div_busy),
    .done (div_done),
    .quot (div_quot),
    .rem  (div_rem),
    .dz   (div_dz)
  );

  // Pick quotient or remainder and form divider flags.
  always_comb begin
    div_res = (alu_sel == OP_MOD) ? div_rem : div_quot;
    div_f   = '0;
    if (div_dz) begin
      div_res = '1;
      div_f.v = 1'b1;
    end else begin
      div_f.z = (div_res == '0);
    end
  end
`else
  assign div_go = 1'b0;
`endif

  // Sequencer FSM with registered ALU drive and response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_f      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
            state   <= div_go ? DIV : ISSUE;
          end
        end
        ISSUE: begin
          rsp_result <= alu_out;
          rsp_f      <= '{z: alu_z, n: alu_n,
                          v: alu_v, c: alu_c};
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          if (div_done) begin
            rsp_result <= div_res;
            rsp_f      <= div_f;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (!div_busy) begin
            state <= IDLE;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-bit ALU.
// Divider latency expectations follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;

  localparam int N = 4;
`ifdef ALU_SEQ_DIV_EN
  localparam int DIV_LAT = N + 1;
`else
  localparam int DIV_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_out;
  logic         alu_z;
  logic         alu_n;
  logic         alu_v;
  logic         alu_c;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_z;
  logic         rsp_n;
  logic         rsp_v;
  logic         rsp_c;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .alu_n     (alu_n),
    .alu_v     (alu_v),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_z     (rsp_z),
    .rsp_n     (rsp_n),
    .rsp_v     (rsp_v),
    .rsp_c     (rsp_c)
  );

  // Behavioural ALU
  logic [4:0] s5;
  logic [7:0] p8;
  always_comb begin
    s5      = '0;
    p8      = '0;
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_sel)
      4'b0000: begin
        s5 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = s5[3:0];
        alu_c = s5[4];
        alu_v = (alu_a[3] == alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      4'b0001: begin
        s5 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = s5[3:0];
        alu_c = s5[4];
        alu_v = (alu_a[3] != alu_b[3]) && (alu_out[3] != alu_a[3]);
      end
      4'b0010: begin
        p8 = alu_a * alu_b;
        alu_out = p8[3:0];
      end
      4'b0011: begin
        if (alu_b == 0) begin alu_out = 4'hF; alu_v = 1'b1; end
        else alu_out = alu_a / alu_b;
      end
      4'b0100: begin
        if (alu_b == 0) begin alu_out = 4'hF; alu_v = 1'b1; end
        else alu_out = alu_a % alu_b;
      end
      4'b0101: alu_out = alu_a & alu_b;
      4'b0110: alu_out = alu_a | alu_b;
      4'b0111: alu_out = alu_a ^ alu_b;
      4'b1000: alu_out = alu_a << 1;
      4'b1001: alu_out = alu_a >> 1;
      default: alu_out = alu_a ^ alu_b ^ 4'h5;
    endcase
    alu_z = (alu_out == 0);
    alu_n = alu_out[3];
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold until accepted; returns in cycle 1.
  task automatic issue(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("cmd_ready_timeout", 8'(n), 8'(0));
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [3:0] seen[$];
  logic [3:0] b2b_op[3];
  logic [3:0] b2b_a[3];
  logic [3:0] b2b_b[3];
  logic [3:0] b2b_exp[3];

  initial begin
    int lat;
    int idx;
    logic acc;
    logic got;
    logic [3:0] res;
    logic [3:0] held;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    chk("rst_cmd_ready", 8'(cmd_ready), 8'(1));
    chk("rst_rsp_valid", 8'(rsp_valid), 8'(0));
    chk("rst_rsp_result", 8'(rsp_result), 8'(0));
    chk("rst_flags", 8'({rsp_z, rsp_n, rsp_v, rsp_c}), 8'(0));
    chk("rst_alu", 8'({alu_a, alu_b}), 8'(0));
    chk("rst_alu_sel", 8'(alu_sel), 8'(0));

    // ADD 3+4 with backpressure
    issue(4'b0000, 4'd3, 4'd4);
    chk("add_alu_sel", 8'(alu_sel), 8'(0));
    chk("add_alu_ab", 8'({alu_a, alu_b}), 8'h34);
    chk("add_cmd_ready_busy", 8'(cmd_ready), 8'(0));
    wait_rsp(lat);
    chk("add_latency", 8'(lat), 8'(2));
    chk("add_result", 8'(rsp_result), 8'(7));
    chk("add_flags", 8'({rsp_z, rsp_n, rsp_v, rsp_c}), 8'b0000);
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 8'(rsp_valid), 8'(1));
      chk("bp_result", 8'(rsp_result), 8'(held));
      chk("bp_cmd_ready", 8'(cmd_ready), 8'(0));
    end
    take();
    chk("bp_release_ready", 8'(cmd_ready), 8'(1));
    chk("bp_release_valid", 8'(rsp_valid), 8'(0));

    // SUB 5-5: zero flag, carry clear
    issue(4'b0001, 4'd5, 4'd5);
    wait_rsp(lat);
    chk("sub_result", 8'(rsp_result), 8'(0));
    chk("sub_flags", 8'({rsp_z, rsp_n, rsp_v, rsp_c}), 8'b1000);
    take();

    // ADD 7+1: signed overflow, negative
    issue(4'b0000, 4'd7, 4'd1);
    wait_rsp(lat);
    chk("ovf_result", 8'(rsp_result), 8'(8));
    chk("ovf_flags", 8'({rsp_z, rsp_n, rsp_v, rsp_c}), 8'b0110);
    take();

    // Undefined op forwarded; 2^1^5 = 6
    issue(4'b1100, 4'd2, 4'd1);
    chk("undef_alu_sel", 8'(alu_sel), 8'hC);
    wait_rsp(lat);
    chk("undef_result", 8'(rsp_result), 8'(6));
    take();

    // DIV 13/4 = 3
    issue(4'b0011, 4'd13, 4'd4);
    chk("div_alu_sel", 8'(alu_sel), 8'h3);
    wait_rsp(lat);
    chk("div_latency", 8'(lat), 8'(DIV_LAT));
    chk("div_result", 8'(rsp_result), 8'(3));
    chk("div_zv", 8'({rsp_z, rsp_v}), 8'b00);
    take();

    // Remainder 13%4 = 1
    issue(4'b0100, 4'd13, 4'd4);
    wait_rsp(lat);
    chk("mod_latency", 8'(lat), 8'(DIV_LAT));
    chk("mod_result", 8'(rsp_result), 8'(1));
    take();

    // DIV 3/5 = 0 -> Z
    issue(4'b0011, 4'd3, 4'd5);
    wait_rsp(lat);
    chk("divz_result", 8'(rsp_result), 8'(0));
    chk("divz_z", 8'(rsp_z), 8'(1));
    take();

    // Divide by zero
    issue(4'b0011, 4'd9, 4'd0);
    wait_rsp(lat);
    chk("dz_latency", 8'(lat), 8'(DIV_LAT));
    chk("dz_result", 8'(rsp_result), 8'hF);
    chk("dz_zv", 8'({rsp_z, rsp_v}), 8'b01);
    take();

    // Reset while an op is in flight
    issue(4'b0011, 4'd13, 4'd4);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_ready", 8'(cmd_ready), 8'(1));
    chk("mid_rst_valid", 8'(rsp_valid), 8'(0));
    chk("mid_rst_result", 8'(rsp_result), 8'(0));
    chk("mid_rst_flags", 8'({rsp_z, rsp_n, rsp_v, rsp_c}), 8'(0));
    chk("mid_rst_alu_sel", 8'(alu_sel), 8'(0));
    for (int i = 0; i < 6; i++) step();
    chk("mid_rst_no_late_rsp", 8'(rsp_valid), 8'(0));

    // Back-to-back with cmd_valid held
    b2b_op[0] = 4'b0000; b2b_a[0] = 4'd1;  b2b_b[0] = 4'd2;
    b2b_exp[0] = 4'd3;
    b2b_op[1] = 4'b0001; b2b_a[1] = 4'd9;  b2b_b[1] = 4'd4;
    b2b_exp[1] = 4'd5;
    b2b_op[2] = 4'b0111; b2b_a[2] = 4'd12; b2b_b[2] = 4'd5;
    b2b_exp[2] = 4'd9;
    idx = 0;
    cmd_op = b2b_op[0];
    cmd_a = b2b_a[0];
    cmd_b = b2b_b[0];
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = cmd_valid && cmd_ready;
      got = rsp_valid && rsp_ready;
      res = rsp_result;
      step();
      if (got) seen.push_back(res);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          cmd_op = b2b_op[idx];
          cmd_a = b2b_a[idx];
          cmd_b = b2b_b[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    chk("b2b_accepts", 8'(idx), 8'(3));
    chk("b2b_count", 8'(seen.size()), 8'(3));
    for (int i = 0; i < 3; i++) begin
      chk("b2b_result", 8'(i < seen.size() ? seen[i] : 4'hX),
          8'(b2b_exp[i]));
    end
    chk("b2b_idle", 8'(cmd_ready), 8'(1));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
